// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multicycle MIPS-subset CPU with a single request/ready memory port
`timescale 1ns/1ps
module multicycle_cpu #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       inst,
    output logic [2:0]        state,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t            st;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] target;
    logic [31:0]       ir;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       aluout;
    logic [31:0]       mdr;
    logic [31:0]       rf [32];
    logic              halted_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [25:0] imm26;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign imm16  = ir[15:0];
    assign imm26  = ir[25:0];
    assign funct  = ir[5:0];

    logic [31:0] imm_ext;
    logic [31:0] br_off;
    logic [31:0] addr_sum;
    logic [31:0] pc_ext;
    logic [31:0] j_target;
    logic [31:0] alu_r;
    logic [31:0] wb_data;
    logic [4:0]  wb_dst;
    logic        is_r;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_addi;
    logic        is_j;
    logic        supported;

    assign imm_ext  = {{16{imm16[15]}}, imm16};
    assign br_off   = imm_ext << 2;
    assign addr_sum = a + imm_ext;

    // Zero-extend the PC so the jump-region math is identical for every ADDR_W
    always_comb begin
        pc_ext             = '0;
        pc_ext[ADDR_W-1:0] = pc_q;
    end

    assign j_target = (pc_ext & 32'hF000_0000) | {4'b0000, imm26, 2'b00};

    // Instruction classification; an R-type with an unknown funct is unsupported
    always_comb begin
        is_r    = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_addi = 1'b0;
        is_j    = 1'b0;
        case (opcode)
            OP_RTYPE: is_r = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                             (funct == FN_OR)  || (funct == FN_SLT);
            OP_LW:    is_lw   = 1'b1;
            OP_SW:    is_sw   = 1'b1;
            OP_BEQ:   is_beq  = 1'b1;
            OP_ADDI:  is_addi = 1'b1;
            OP_J:     is_j    = 1'b1;
            default:  ;
        endcase
        supported = is_r | is_lw | is_sw | is_beq | is_addi | is_j;
    end

    // R-type ALU: wrap-around arithmetic, signed compare for slt
    always_comb begin
        case (funct)
            FN_SUB:  alu_r = a - b;
            FN_AND:  alu_r = a & b;
            FN_OR:   alu_r = a | b;
            FN_SLT:  alu_r = {31'd0, ($signed(a) < $signed(b))};
            default: alu_r = a + b;
        endcase
    end

    // Write-back destination and data selection
    always_comb begin
        wb_dst  = rt;
        wb_data = aluout;
        if (is_r) begin
            wb_dst = rd;
        end else if (is_lw) begin
            wb_data = mdr;
        end
    end

    // Request is gated by rst_n so it drops the instant reset asserts, and rises
    // straight away on release; the address/data only change on state transitions.
    assign mem_req   = rst_n && ((st == S_FETCH) || (st == S_MEM));
    assign mem_we    = (st == S_MEM) && is_sw;
    assign mem_addr  = (st == S_MEM) ? {aluout[ADDR_W-1:2], 2'b00} : {pc_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = b;

    assign pc     = pc_q;
    assign inst   = ir;
    assign state  = st;
    assign halted = halted_q;

    // Main FSM with all architectural state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_FETCH;
            pc_q     <= RESET_PC;
            target   <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            aluout   <= '0;
            mdr      <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (st)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir   <= mem_rdata;
                        pc_q <= pc_q + ADDR_W'(4);
                        st   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= rf[rs];
                    b      <= rf[rt];
                    target <= pc_q + br_off[ADDR_W-1:0];
                    if (supported) begin
                        st <= S_EXEC;
                    end else begin
                        st       <= S_HALT;
                        halted_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_r) begin
                        aluout <= alu_r;
                        st     <= S_WB;
                    end else if (is_addi) begin
                        aluout <= addr_sum;
                        st     <= S_WB;
                    end else if (is_lw || is_sw) begin
                        aluout <= addr_sum;
                        st     <= S_MEM;
                    end else if (is_beq) begin
                        if (a == b) begin
                            pc_q <= target;
                        end
                        st <= S_FETCH;
                    end else begin
                        pc_q <= j_target[ADDR_W-1:0];
                        st   <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_sw) begin
                            st <= S_FETCH;
                        end else begin
                            mdr <= mem_rdata;
                            st  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_dst != 5'd0) begin
                        rf[wb_dst] <= wb_data;
                    end
                    st <= S_FETCH;
                end
                default: begin
                    st       <= S_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - randomized program bench for multicycle_cpu against an ISA-level model
`timescale 1ns/1ps
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  state;
    logic        halted;

    multicycle_cpu #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .inst      (inst),
        .state     (state),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rf  [32];
    logic [31:0] ref_pc;
    bit          ref_halt;
    bit          ref_is_sw;
    int          exp_cycles;
    logic [31:0] exp_daddr;
    logic [31:0] exp_wdata;
    int          fetch_cyc [$];
    logic [31:0] fetch_pc  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic void ref_wr(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) ref_rf[idx] = v;
    endfunction

    // Executes one instruction at ISA level and records what the bus should show
    task automatic ref_step();
        logic [31:0] w, a, b, se, r;
        logic [4:0]  rs, rt, rd;
        w  = ref_mem[ref_pc[9:2]];
        ref_pc = ref_pc + 32'd4;
        rs = w[25:21];
        rt = w[20:16];
        rd = w[15:11];
        a  = ref_rf[rs];
        b  = ref_rf[rt];
        se = {{16{w[15]}}, w[15:0]};
        r  = '0;
        ref_is_sw = 1'b0;
        case (w[31:26])
            6'h00: begin
                case (w[5:0])
                    6'h20:   r = a + b;
                    6'h22:   r = a - b;
                    6'h24:   r = a & b;
                    6'h25:   r = a | b;
                    6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: ref_halt = 1'b1;
                endcase
                if (!ref_halt) begin
                    ref_wr(rd, r);
                    exp_cycles = 4;
                end
            end
            6'h08: begin ref_wr(rt, a + se); exp_cycles = 4; end
            6'h23: begin
                exp_daddr = (a + se) & ~32'd3;
                ref_wr(rt, ref_mem[exp_daddr[9:2]]);
                exp_cycles = 5;
            end
            6'h2B: begin
                exp_daddr = (a + se) & ~32'd3;
                exp_wdata = b;
                ref_is_sw = 1'b1;
                ref_mem[exp_daddr[9:2]] = b;
                exp_cycles = 4;
            end
            6'h04: begin
                if (a == b) ref_pc = ref_pc + (se << 2);
                exp_cycles = 3;
            end
            6'h02: begin
                ref_pc = {ref_pc[31:28], w[25:0], 2'b00};
                exp_cycles = 3;
            end
            default: ref_halt = 1'b1;
        endcase
    endtask

    // Resets the CPU and runs it in lockstep with the model, acting as the memory
    task automatic run_prog(input int wmin, input int wmax, input int max_inst);
        int          cyc, ninst, last_cyc, waits_acc, wl;
        bit          in_txn, t_we, t_fetch;
        logic [31:0] t_addr, t_wdata, cur_pc;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        ref_pc = 32'h0; ref_halt = 1'b0; ref_is_sw = 1'b0; exp_cycles = 0;
        fetch_cyc.delete(); fetch_pc.delete();
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_pc", pc, 0);
        check("rst_state", state, 0);
        check("rst_inst", inst, 0);
        check("rst_halted", halted, 0);
        rst_n = 1'b1;
        #1;
        check("rel_req", mem_req, 1);
        cyc = 0; ninst = 0; last_cyc = 0; waits_acc = 0; wl = 0;
        in_txn = 1'b0; t_we = 1'b0; t_fetch = 1'b0; t_addr = '0; t_wdata = '0; cur_pc = '0;
        while (1) begin
            if (state == 3'd0 && !in_txn && !ref_halt) begin
                if (ninst > 0) check("cpi", cyc - last_cyc, exp_cycles + waits_acc);
                if (ninst == max_inst) break;
                waits_acc = 0; last_cyc = cyc;
                fetch_cyc.push_back(cyc); fetch_pc.push_back(pc);
                check("pc", pc, ref_pc);
                cur_pc = ref_pc;
                ref_step();
                ninst++;
            end
            if (ref_halt && state == 3'd5) break;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wl = $urandom_range(wmax, wmin);
                    waits_acc += wl;
                    t_we = mem_we; t_addr = mem_addr; t_wdata = mem_wdata;
                    t_fetch = (state == 3'd0);
                    if (t_fetch) begin
                        check("fetch_addr", mem_addr, cur_pc);
                        check("fetch_we", mem_we, 0);
                    end else begin
                        check("data_addr", mem_addr, exp_daddr);
                        check("data_we", mem_we, {31'd0, ref_is_sw});
                    end
                end else begin
                    check("hold_addr", mem_addr, t_addr);
                    check("hold_we", mem_we, t_we);
                    check("hold_wdata", mem_wdata, t_wdata);
                end
                if (wl == 0) begin
                    mem_ready = 1'b1;
                    if (t_we) begin
                        check("st_data", t_wdata, exp_wdata);
                        mem[t_addr[9:2]] = t_wdata;
                    end else begin
                        mem_rdata = mem[t_addr[9:2]];
                    end
                    in_txn = 1'b0;
                end else begin
                    wl--;
                end
            end else begin
                if (in_txn) check("req_held", mem_req, 1);
                in_txn = 1'b0;
                mem_ready = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                check("timeout", cyc, 4000);
                break;
            end
        end
        if (ref_halt) begin
            check("halted", halted, 1);
            check("halt_pc", pc, ref_pc);
            for (int c = 0; c < 20; c++) begin
                mem_ready = $urandom_range(0, 1);
                mem_rdata = $urandom;
                @(negedge clk);
                check("halt_req", mem_req, 0);
                check("halt_state", state, 5);
            end
            check("halt_pc_hold", pc, ref_pc);
        end
        for (int i = 0; i < 32; i++) check($sformatf("reg%0d", i), dut.rf[i], ref_rf[i]);
        for (int i = 64; i < 128; i++) check($sformatf("dmem%0d", i), mem[i], ref_mem[i]);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic gen_prog();
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        int n;
        n = $urandom_range(12, 30);
        for (int i = 0; i < 256; i++) mem[i] = (i >= 64 && i < 128) ? $urandom : 32'h0;
        for (int i = 0; i < n; i++) begin
            int k, rs, rt, rd, span, t;
            k  = $urandom_range(0, 9);
            rs = $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            rd = $urandom_range(0, 7);
            span = (n - i - 1 < 3) ? n - i - 1 : 3;
            t  = i + 1 + $urandom_range(0, span);
            case (k)
                5:       mem[i] = enc_i(6'h08, rs, rt, 16'($urandom));
                6:       mem[i] = enc_i(6'h23, 0, rt, 16'(256 + 4 * $urandom_range(0, 63)));
                7:       mem[i] = enc_i(6'h2B, 0, rt, 16'(256 + 4 * $urandom_range(0, 63)));
                8:       mem[i] = enc_i(6'h04, rs, rt, 16'(t - i - 1));
                9:       mem[i] = {6'h02, 26'(t)};
                default: mem[i] = enc_r(rs, rt, rd, fns[k]);
            endcase
        end
        mem[n] = ($urandom_range(0, 1) == 1) ? 32'hFC00_0000 : enc_r(1, 2, 3, 6'h21);
    endtask

    initial begin
        // addi/addi/add with zero-wait memory
        clear_mem();
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_FFFD;
        mem[2] = 32'h0022_1820;
        mem[3] = 32'hFC00_0000;
        run_prog(0, 0, 1000);
        check("A_cyc12", fetch_cyc[3], 12);
        check("A_pc12", fetch_pc[3], 32'd12);
        check("A_r3", dut.rf[3], 2);

        // sw then lw with three wait cycles per access
        clear_mem();
        mem[0]  = 32'h2001_0005;
        mem[1]  = {6'h02, 26'd16};
        mem[16] = 32'hAC01_0008;
        mem[17] = 32'h8C04_0008;
        mem[18] = 32'hFC00_0000;
        run_prog(3, 3, 1000);
        check("B_mem8", mem[2], 5);
        check("B_r4", dut.rf[4], 5);
        check("B_lw_cyc", fetch_cyc[4] - fetch_cyc[3], 11);
        check("B_sw_cyc", fetch_cyc[3] - fetch_cyc[2], 10);

        // slt and a taken beq looping on itself
        clear_mem();
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_FFFD;
        mem[2] = 32'h0022_1820;
        mem[3] = 32'h0041_282A;
        mem[4] = 32'h1021_FFFF;
        run_prog(0, 0, 7);
        check("C_r5", dut.rf[5], 1);
        check("C_beq_pc", fetch_pc[5], 32'h10);
        check("C_beq_pc2", fetch_pc[6], 32'h10);
        check("C_beq_cyc", fetch_cyc[6] - fetch_cyc[5], 3);

        // add into $0 is discarded, not-taken beq falls through
        clear_mem();
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h0021_0020;
        mem[2] = 32'h0021_0020;
        mem[3] = 32'h0021_0020;
        mem[4] = 32'h1020_FFFF;
        mem[5] = 32'hFC00_0000;
        run_prog(0, 0, 1000);
        check("D_r0", dut.rf[0], 0);
        check("D_beq_pc", fetch_pc[5], 32'h14);
        check("D_beq_cyc", fetch_cyc[5] - fetch_cyc[4], 3);

        // unsupported opcode as the very first instruction
        clear_mem();
        mem[0] = 32'hFC00_0000;
        run_prog(0, 2, 1000);
        check("E_state", state, 5);

        // random programs with random wait states
        for (int p = 0; p < 8; p++) begin
            gen_prog();
            run_prog(0, $urandom_range(0, 3), 1000);
        end

        // reset pulsed during a fetch wait
        clear_mem();
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_FFFD;
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("R_req1", mem_req, 1);
        check("R_addr1", mem_addr, 0);
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr[9:2]];
            @(negedge clk);
        end
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("R_wait_req", mem_req, 1);
        check("R_pre_r1", dut.rf[1], 5);
        check("R_pre_pc", pc, 4);
        #2 rst_n = 1'b0;
        #1;
        check("R_req0", mem_req, 0);
        check("R_pc0", pc, 0);
        check("R_r1", dut.rf[1], 0);
        check("R_state", state, 0);
        check("R_inst", inst, 0);
        @(negedge clk);
        check("R_req_held0", mem_req, 0);
        rst_n = 1'b1;
        #1;
        check("R_refetch_req", mem_req, 1);
        check("R_refetch_addr", mem_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
  ADDR_W    32  memory address and PC width, legal range 8..32
  RESET_PC  0   PC value loaded at reset, word aligned
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
  clk        in   1       single clock; all state updates on its rising edge
  rst_n      in   1       asynchronous, active-low reset
  mem_req    out  1       memory request valid
  mem_we     out  1       1 = write, 0 = read; valid while mem_req is high
  mem_addr   out  ADDR_W  word address; bits [1:0] are always 0
  mem_wdata  out  32      store data
  mem_rdata  in   32      read data; valid in the cycle mem_ready is high
  mem_ready  in   1       transfer completes on a clock edge where mem_req and mem_ready are both high
  pc         out  ADDR_W  current PC
  inst       out  32      instruction register
  state      out  3       FSM state code
  halted     out  1       high while in HALT

Function
REQ-003 FSM state codes SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-004 FETCH SHALL drive mem_req=1, mem_we=0 and mem_addr=PC; on mem_ready the block SHALL load IR<=mem_rdata, set PC<=PC+4 (mod 2^ADDR_W) and go to DECODE.
REQ-005 DECODE SHALL latch A=reg[rs], B=reg[rt] and branch target=PC+(sign-extended imm16<<2); it SHALL go to HALT on any unsupported opcode or funct, otherwise to EXEC.
REQ-006 The supported instructions SHALL be:
  R-type opcode 000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010
  lw 100011, sw 101011, beq 000100, addi 001000, j 000010
REQ-007 EXEC SHALL behave as follows: R-type ALUOut<=A op B; addi, lw and sw ALUOut<=A+signext(imm16); these go to WB (R-type, addi) or MEM (lw, sw).
REQ-008 EXEC for beq SHALL set PC<=target when A==B and go to FETCH.
REQ-009 EXEC for j SHALL set PC<={PC[31:28], imm26, 2'b00} truncated to ADDR_W and go to FETCH.
REQ-010 ALU arithmetic SHALL be 32-bit wrap-around with no overflow trap; slt SHALL compare signed and produce 1 or 0.
REQ-011 MEM SHALL drive mem_req=1 and mem_addr=ALUOut[ADDR_W-1:2],2'b00.
REQ-012 In MEM, lw SHALL use mem_we=0 and capture MDR on mem_ready, then go to WB; sw SHALL use mem_we=1 and mem_wdata=B, and go to FETCH on mem_ready.
REQ-013 WB SHALL write ALUOut to rd (R-type), ALUOut to rt (addi) or MDR to rt (lw), then go to FETCH.
REQ-014 The register file SHALL hold 32 x 32-bit registers; writes to register 0 SHALL be discarded and reads of register 0 SHALL return 0.
REQ-015 While waiting for mem_ready, mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable; mem_ready SHALL be ignored when mem_req is low.
REQ-016 mem_req SHALL be low in DECODE, EXEC, WB and HALT.
REQ-017 With zero-wait memory (mem_ready held high), cycles per instruction SHALL be: R-type/addi 4, lw 5, sw 4, beq 3, j 3; each memory wait cycle SHALL add exactly one cycle.
REQ-018 HALT SHALL be absorbing until reset: no register, PC or memory updates, halted=1.

Reset
REQ-019 While rst_n is low, the block SHALL immediately force PC=RESET_PC, IR=0, A=B=ALUOut=MDR=0, all registers 0, state=FETCH, halted=0, mem_req=0, mem_we=0.
REQ-020 Reset asserted mid-transaction SHALL drop mem_req in the same cycle with no register or PC write.
REQ-021 In the first cycle after rst_n rises, mem_req SHALL be 1 with mem_addr=RESET_PC.

Verification
REQ-022 Directed scenarios:
  - addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2, zero-wait -> reg3=2, PC=12 after 12 cycles.
  - sw $1,8($0) then lw $4,8($0), mem_ready delayed 3 cycles per access -> store addr 8 data 5 with signals stable while waiting; reg4=5; lw takes 5+6 cycles.
  - beq $1,$1,-1 at PC 0x10 -> PC returns to 0x10; beq with A!=B -> PC=0x14; each 3 cycles.
  - slt $5,$2,$1 with $2=-3, $1=5 -> reg5=1; add $0,$1,$1 -> reg0 still 0.
  - opcode 111111 fetched -> state=5, halted=1, mem_req stays 0 for 20 cycles.
  - rst_n pulsed low during a FETCH wait -> mem_req=0 at once, PC=RESET_PC, registers 0, refetch from RESET_PC after release.
